// File: rtl/dma_copy.sv
// dma_copy: memory-to-memory word copy engine.
//
// Second initiator on the shared data bus. The core configures it through a
// 16-byte MMIO window (SRC, DST, LEN, CTRL/STAT). After a start, the engine
// requests the bus and alternates READ / WRITE cycles under bus_grant until
// LEN words are copied. It then sets a sticky done flag, which drives irq.
//
// Optional build macro: DMA_FILL_EN
//   CTRL bit2 selects fill mode; it is latched at start.
//   In fill mode the READ cycles are skipped, so each word takes one cycle.
//   Every WRITE carries the value last written to SRC, and SRC does not advance.
//
// Ports:
//   clk, rst          system clock; synchronous active-high reset
//   cfg_address       core data address (window decode + register offset)
//   cfg_write_data    core write data
//   cfg_rw            core write strobe (1 = write)
//   cfg_read_data     register read data, 0 when the window is not selected
//   cfg_selected      combinational window hit
//   bus_req           master bus request, high from REQ until the last write
//   bus_grant         arbiter grant; strobes are only driven while it is high
//   m_address         master word address (0 when no strobe)
//   m_write_data      master write data (0 when no write strobe)
//   m_read_sig        master read strobe
//   m_write_sig       master write strobe
//   m_read_data       read data, valid in the same cycle as m_read_sig
//   irq               level interrupt, equals the done flag
//
// Handshake: a master strobe completes in the cycle it is asserted. The
// strobes are combinational in bus_grant, so dropping the grant pauses the
// transfer in place with no partial beat.
module dma_copy #(
    parameter logic [31:0] MMIO_BASE_DMA = 32'hA000_0000,
    parameter logic [31:0] MMIO_MASK_DMA = 32'hFFFF_FFF0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] cfg_address,
    input  logic [31:0] cfg_write_data,
    input  logic        cfg_rw,
    output logic [31:0] cfg_read_data,
    output logic        cfg_selected,
    output logic        bus_req,
    input  logic        bus_grant,
    output logic [31:0] m_address,
    output logic [31:0] m_write_data,
    output logic        m_read_sig,
    output logic        m_write_sig,
    input  logic [31:0] m_read_data,
    output logic        irq
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_READ  = 2'd2,
        S_WRITE = 2'd3
    } state_t;

    state_t      r_state;
    logic [31:0] r_src;
    logic [31:0] r_dst;
    logic [31:0] r_len;
    logic [31:0] r_buf;
    logic        r_done;

    logic [1:0]  w_off;
    logic        w_wr;
    logic        w_busy;
    logic        w_start;
    logic        w_clr;
    logic        w_fill;
    logic [31:0] w_wdata;

    assign cfg_selected = ((cfg_address & MMIO_MASK_DMA) == MMIO_BASE_DMA);
    assign w_off        = cfg_address[3:2];
    assign w_wr         = cfg_selected && cfg_rw;
    assign w_busy       = (r_state != S_IDLE);
    // A start while busy is dropped here, so IDLE is the only place it can act.
    assign w_start      = w_wr && (w_off == 2'd3) && cfg_write_data[0] && !w_busy;
    assign w_clr        = w_wr && (w_off == 2'd3) && cfg_write_data[1];

`ifdef DMA_FILL_EN
    logic        r_fill;
    // The full 32-bit SRC write is kept as the fill pattern. The SRC address
    // register itself drops bits [1:0].
    logic [31:0] r_pat;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fill <= 1'b0;
            r_pat  <= 32'd0;
        end else begin
            if (w_start) begin
                r_fill <= cfg_write_data[2];
            end
            if (w_wr && (w_off == 2'd0) && !w_busy) begin
                r_pat <= cfg_write_data;
            end
        end
    end

    assign w_fill  = r_fill;
    assign w_wdata = r_fill ? r_pat : r_buf;
`else
    assign w_fill  = 1'b0;
    assign w_wdata = r_buf;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_src   <= 32'd0;
            r_dst   <= 32'd0;
            r_len   <= 32'd0;
            r_buf   <= 32'd0;
            r_done  <= 1'b0;
        end else begin
            // The clear comes first so that a done set later in this block wins.
            if (w_clr) begin
                r_done <= 1'b0;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_wr) begin
                        case (w_off)
                            2'd0:    r_src <= {cfg_write_data[31:2], 2'b00};
                            2'd1:    r_dst <= {cfg_write_data[31:2], 2'b00};
                            2'd2:    r_len <= cfg_write_data;
                            default: ;
                        endcase
                    end
                    if (w_start) begin
                        if (r_len == 32'd0) begin
                            r_done <= 1'b1;
                        end else begin
                            r_state <= S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    if (bus_grant) begin
                        r_state <= w_fill ? S_WRITE : S_READ;
                    end
                end
                S_READ: begin
                    if (bus_grant) begin
                        r_buf   <= m_read_data;
                        r_state <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (bus_grant) begin
                        r_dst <= r_dst + 32'd4;
                        if (!w_fill) begin
                            r_src <= r_src + 32'd4;
                        end
                        r_len <= r_len - 32'd1;
                        if (r_len == 32'd1) begin
                            r_done  <= 1'b1;
                            r_state <= S_IDLE;
                        end else begin
                            r_state <= w_fill ? S_WRITE : S_READ;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus_req      = w_busy;
    assign m_read_sig   = (r_state == S_READ) && bus_grant;
    assign m_write_sig  = (r_state == S_WRITE) && bus_grant;
    assign m_address    = m_read_sig ? r_src : (m_write_sig ? r_dst : 32'd0);
    assign m_write_data = m_write_sig ? w_wdata : 32'd0;
    assign irq          = r_done;

    always_comb begin
        cfg_read_data = 32'd0;
        if (cfg_selected) begin
            case (w_off)
                2'd0:    cfg_read_data = r_src;
                2'd1:    cfg_read_data = r_dst;
                2'd2:    cfg_read_data = r_len;
                default: cfg_read_data = {29'd0, w_fill, r_done, w_busy};
            endcase
        end
    end

endmodule
